// File: rtl/bht_predictor_pkg.sv
// bht_predictor_pkg: shared constants for the branch history table
package bht_predictor_pkg;
    typedef enum logic [1:0] {BHT_SNT = 2'b00, BHT_WNT = 2'b01, BHT_WT = 2'b10, BHT_ST = 2'b11} bht_cnt_e;
    localparam int BHT_IDX_W = 7;
endpackage

// File: rtl/bht_predictor_sat_cnt2.sv
// bht_sat_cnt2: 2-bit saturating counter next state (cnt_i, taken_i -> cnt_o)
module bht_sat_cnt2
    import bht_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);
    always_comb begin
        cnt_o = taken_i ? (cnt_i == BHT_ST  ? cnt_i : cnt_i + 2'd1)
                        : (cnt_i == BHT_SNT ? cnt_i : cnt_i - 2'd1);
    end
endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: 2-bit counter BHT, combinational prediction for IF, staged update from EX
// Ports: clk/rst (sync, active-high), rdy freezes state; if_pc_i -> pred_taken_o;
//        p_we_i/p_addr_i/p_res_taken_i/ex_stall_i update request from EX.
// Option: BHT_BYPASS_EN forwards the staged update into the prediction.
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int         IDX_W    = BHT_IDX_W,
    parameter logic [1:0] CNT_INIT = BHT_WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    input  logic        p_we_i,
    input  logic [31:0] p_addr_i,
    input  logic        p_res_taken_i,
    input  logic        ex_stall_i
);
    logic [1:0]       cnt [2**IDX_W];
    logic             stg_v;
    logic [IDX_W-1:0] stg_idx;
    logic             stg_tk;
    logic [1:0]       upd;
    logic [IDX_W-1:0] q_idx;

    assign q_idx = if_pc_i[IDX_W+1:2];

    bht_sat_cnt2 u_sat (
        .cnt_i  (cnt[stg_idx]),
        .taken_i(stg_tk),
        .cnt_o  (upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= CNT_INIT;
            stg_v <= 1'b0;
        end else if (rdy) begin
            stg_v   <= p_we_i & ~ex_stall_i;
            stg_idx <= p_addr_i[IDX_W+1:2];
            stg_tk  <= p_res_taken_i;
            if (stg_v) cnt[stg_idx] <= upd;
        end
    end

`ifdef BHT_BYPASS_EN
    always_comb begin
        pred_taken_o = (rst || !rdy) ? 1'b0 : (stg_v && stg_idx == q_idx) ? upd[1] : cnt[q_idx][1];
    end
`else
    always_comb begin
        pred_taken_o = (rst || !rdy) ? 1'b0 : cnt[q_idx][1];
    end
`endif
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: randomized + directed check of bht_predictor against a counter-array model
module tb_bht_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic        p_tk = 1'b0;
    logic        ex_stall = 1'b0;

    int checks = 0;
    int failures = 0;

    int m_cnt [128];
    bit m_pend = 0;
    int m_pidx = 0;
    bit m_ptk = 0;

    always #5 clk = ~clk;

    bht_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .if_pc_i      (if_pc),
        .pred_taken_o (pred),
        .p_we_i       (p_we),
        .p_addr_i     (p_addr),
        .p_res_taken_i(p_tk),
        .ex_stall_i   (ex_stall)
    );

    function automatic int sat(int c, bit tk);
        return tk ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
    endfunction

    function automatic bit model_pred(logic [31:0] pc);
        int q = int'(pc[8:2]);
        if (rst || !rdy) return 1'b0;
`ifdef BHT_BYPASS_EN
        if (m_pend && m_pidx == q) return sat(m_cnt[q], m_ptk) >= 2;
`endif
        return m_cnt[q] >= 2;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s pc=%h got=%b expected=%b at %0t", tag, if_pc, got, exp, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic rd, input logic we, input logic st,
                       input logic [31:0] a, input logic tk, input logic [31:0] q);
        rst = r; rdy = rd; p_we = we; ex_stall = st; p_addr = a; p_tk = tk; if_pc = q;
        @(posedge clk);
        if (r) begin
            foreach (m_cnt[i]) m_cnt[i] = 1;
            m_pend = 0;
        end else if (rd) begin
            if (m_pend) m_cnt[m_pidx] = sat(m_cnt[m_pidx], m_ptk);
            m_pend = we & ~st;
            m_pidx = int'(a[8:2]);
            m_ptk = tk;
        end
        #1;
        check(tag, pred, model_pred(q));
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 1;
        cyc("reset", 1, 1, 1, 0, 32'h100, 1, 32'h100);
        cyc("reset", 1, 1, 0, 0, 32'h100, 1, 32'h100);
        cyc("idle", 0, 1, 0, 0, 0, 0, 32'h100);
        for (int i = 0; i < 128; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            check("reset_sweep", pred, 1'b0);
        end
        for (int i = 0; i < 3; i++) cyc("taken_up", 0, 1, 1, 0, 32'h100, 1, 32'h100);
        for (int i = 0; i < 3; i++) cyc("taken_drain", 0, 1, 0, 0, 0, 0, 32'h100);
        check("saturate_st", pred, 1'b1);
        for (int i = 0; i < 4; i++) cyc("nt_down", 0, 1, 1, 0, 32'h100, 0, 32'h100);
        for (int i = 0; i < 3; i++) cyc("nt_drain", 0, 1, 0, 0, 0, 0, 32'h100);
        check("saturate_snt", pred, 1'b0);
        for (int i = 0; i < 5; i++) cyc("stall_hold", 0, 1, 1, 1, 32'h200, 1, 32'h200);
        cyc("stall_drop", 0, 1, 1, 0, 32'h200, 1, 32'h200);
        for (int i = 0; i < 3; i++) cyc("stall_drain", 0, 1, 0, 0, 0, 0, 32'h200);
        check("stall_one_update", pred, 1'b1);
        cyc("rdy_cap", 0, 1, 1, 0, 32'h400, 1, 32'h400);
        for (int i = 0; i < 3; i++) cyc("rdy_low", 0, 0, 1, 0, 32'h404, 1, 32'h400);
        cyc("rdy_apply", 0, 1, 0, 0, 0, 0, 32'h400);
        check("rdy_applied", pred, 1'b1);
        cyc("rdy_next", 0, 1, 0, 0, 0, 0, 32'h404);
        check("rdy_dropped", pred, 1'b0);
        cyc("rst_cap", 0, 1, 1, 0, 32'h500, 1, 32'h500);
        cyc("rst_discard", 1, 1, 0, 0, 0, 0, 32'h500);
        cyc("rst_after", 0, 1, 0, 0, 0, 0, 32'h500);
        check("rst_discarded", pred, 1'b0);
        cyc("alias_a", 0, 1, 1, 0, 32'h300, 1, 32'h100);
        cyc("alias_b", 0, 1, 1, 0, 32'h300, 1, 32'h100);
        cyc("alias_c", 0, 1, 0, 0, 0, 0, 32'h100);
        check("alias_shared", pred, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, q;
            a = {$urandom_range(7, 0) << 9} | (32'($urandom_range(5, 0)) << 2) | 32'($urandom_range(3, 0));
            q = ($urandom_range(1, 0) != 0) ? a : ({$urandom_range(7, 0) << 9} | (32'($urandom_range(5, 0)) << 2));
            cyc("random", $urandom_range(199, 0) == 0, $urandom_range(9, 0) != 0, $urandom_range(3, 0) != 0,
                $urandom_range(4, 0) == 0, a, $urandom_range(2, 0) != 0, q);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
